// File: rtl/dsp_chain_pkg.sv
// Shared definitions for the sop2 accumulate lane array.
//   A_OFF..D_OFF : position of each operand inside a lane word, in units of IN_W
//                  (a sits at bit 0, b at IN_W, c at 2*IN_W, d at 3*IN_W)
//   PIPE_LAT     : accepted-to-visible latency in clock edges
//   sat()        : clamp a sign-extended value into a signed out_w-bit range
package dsp_chain_pkg;

    localparam int unsigned PIPE_LAT = 3;

    localparam int unsigned A_OFF = 0;
    localparam int unsigned B_OFF = 1;
    localparam int unsigned C_OFF = 2;
    localparam int unsigned D_OFF = 3;

    // Wide enough for any ACC_W the array is built with (ACC_W < SAT_W).
    localparam int unsigned SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int unsigned           out_w);
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] r;
        lo = {SAT_W{1'b1}} << (out_w - 1);  // -2^(out_w-1)
        hi = ~lo;                           //  2^(out_w-1)-1
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_sop2_acc_lane.sv
// One sop2 lane: S2 product registers, S3 sum / accumulate / saturate.
//   clk, reset : clock, synchronous active-high reset
//   en         : pipeline advance (low while the output is stalled)
//   s3_fire    : a valid beat leaves S2 on this edge
//   s2_acc     : that beat is an accumulate beat
//   s2_last    : that beat closes its accumulation group
//   s1_ops     : S1 operand word {d, c, b, a}
//   out_data   : saturated lane result, updated only by emitting beats
module dsp_sop2_acc_lane
    import dsp_chain_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned OUT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              s3_fire,
    input  logic              s2_acc,
    input  logic              s2_last,
    input  logic [4*IN_W-1:0] s1_ops,
    output logic [OUT_W-1:0]  out_data
);

    localparam int unsigned P_W = 2 * IN_W;
    localparam int unsigned S_W = 2 * IN_W + 1;

    logic signed [IN_W-1:0]  op_a, op_b, op_c, op_d;
    logic signed [P_W-1:0]   p0_d, p0_q, p1_d, p1_q;
    logic signed [S_W-1:0]   s;
    logic signed [ACC_W-1:0] s_ext, acc_sum, acc_d, acc_q;
    logic [OUT_W-1:0]        out_d, out_q;

    always_comb begin
        op_a = s1_ops[A_OFF*IN_W +: IN_W];
        op_b = s1_ops[B_OFF*IN_W +: IN_W];
        op_c = s1_ops[C_OFF*IN_W +: IN_W];
        op_d = s1_ops[D_OFF*IN_W +: IN_W];
        p0_d = p0_q;
        p1_d = p1_q;
        if (en) begin
            p0_d = P_W'(op_a) * P_W'(op_b);
            p1_d = P_W'(op_c) * P_W'(op_d);
        end
    end

    // One guard bit lets (-2^(IN_W-1))^2 * 2 = 2^(2*IN_W-1) stay positive.
    always_comb begin
        s       = {p0_q[P_W-1], p0_q} + {p1_q[P_W-1], p1_q};
        s_ext   = {{(ACC_W-S_W){s[S_W-1]}}, s};
        acc_sum = acc_q + s_ext;
        acc_d   = acc_q;
        out_d   = out_q;
        if (s3_fire) begin
            if (!s2_acc) begin
                out_d = OUT_W'(sat({{(SAT_W-ACC_W){s_ext[ACC_W-1]}}, s_ext}, OUT_W));
            end else if (!s2_last) begin
                acc_d = acc_sum;
            end else begin
                out_d = OUT_W'(sat({{(SAT_W-ACC_W){acc_sum[ACC_W-1]}}, acc_sum}, OUT_W));
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p0_q  <= '0;
            p1_q  <= '0;
            acc_q <= '0;
            out_q <= '0;
        end else begin
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out_data = out_q;

endmodule

// File: rtl/dsp_chain_sop2_acc_lanes.sv
// LANES-wide sop2 (a*b + c*d) array with per-lane accumulate and saturation.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : input beat handshake
//   in_data              : lane i at [i*4*IN_W +: 4*IN_W], {d, c, b, a}
//   in_acc, in_last      : accumulate mode / end of accumulation group
//   out_valid / out_ready: result handshake
//   out_data             : lane i result at [i*OUT_W +: OUT_W]
// The top owns the shared valid/flag pipeline and the stall; lanes own data.
module dsp_chain_sop2_acc_lanes
    import dsp_chain_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*4*IN_W-1:0] in_data,
    input  logic                    in_acc,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*OUT_W-1:0]  out_data
);

    localparam int unsigned LANE_W = 4 * IN_W;

    logic                    stall, en, s3_fire;
    logic                    s1_valid_d, s1_valid_q, s1_acc_d, s1_acc_q, s1_last_d, s1_last_q;
    logic                    s2_valid_d, s2_valid_q, s2_acc_d, s2_acc_q, s2_last_d, s2_last_q;
    logic                    out_valid_d, out_valid_q;
    logic [LANES*LANE_W-1:0] s1_data_d, s1_data_q;

    always_comb begin
        stall   = out_valid_q && !out_ready;
        en      = !stall;
        s3_fire = s2_valid_q && en;

        s1_valid_d  = s1_valid_q;
        s1_acc_d    = s1_acc_q;
        s1_last_d   = s1_last_q;
        s1_data_d   = s1_data_q;
        s2_valid_d  = s2_valid_q;
        s2_acc_d    = s2_acc_q;
        s2_last_d   = s2_last_q;
        out_valid_d = out_valid_q;
        if (en) begin
            s1_valid_d  = in_valid;
            s1_acc_d    = in_acc;
            s1_last_d   = in_last && in_acc;
            s1_data_d   = in_data;
            s2_valid_d  = s1_valid_q;
            s2_acc_d    = s1_acc_q;
            s2_last_d   = s1_last_q;
            // Non-emitting accumulate beats present no new result downstream.
            out_valid_d = s2_valid_q && (!s2_acc_q || s2_last_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_acc_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_acc_q    <= s1_acc_d;
            s1_last_q   <= s1_last_d;
            s1_data_q   <= s1_data_d;
            s2_valid_q  <= s2_valid_d;
            s2_acc_q    <= s2_acc_d;
            s2_last_q   <= s2_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        dsp_sop2_acc_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .s3_fire  (s3_fire),
            .s2_acc   (s2_acc_q),
            .s2_last  (s2_last_q),
            .s1_ops   (s1_data_q[gi*LANE_W +: LANE_W]),
            .out_data (out_data[gi*OUT_W +: OUT_W])
        );
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dsp_chain_sop2_acc_lanes.sv
// Directed bench for dsp_chain_sop2_acc_lanes (LANES=8, IN_W=16, ACC_W=48, OUT_W=32).
module tb_dsp_chain_sop2_acc_lanes;
    import dsp_chain_pkg::*;

    localparam int unsigned LANES = 8;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned ACC_W = 48;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned DW    = LANES * 4 * IN_W;
    localparam int unsigned OW    = LANES * OUT_W;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_acc;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [OW-1:0] obs_q[$];

    dsp_chain_sop2_acc_lanes #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change at posedge+1, so the negedge view is what the next edge takes.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) obs_q.push_back(out_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [OUT_W-1:0] sat_ref(input longint x);
        if (x > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (x < -64'sd2147483648) return 32'h8000_0000;
        return x[31:0];
    endfunction

    function automatic longint lane_s(input logic [DW-1:0] v, input int l);
        logic signed [15:0] a, b, c, d;
        a = v[l*64      +: 16];
        b = v[l*64 + 16 +: 16];
        c = v[l*64 + 32 +: 16];
        d = v[l*64 + 48 +: 16];
        return longint'(a) * longint'(b) + longint'(c) * longint'(d);
    endfunction

    function automatic logic [OW-1:0] exp_plain(input logic [DW-1:0] v);
        logic [OW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*OUT_W +: OUT_W] = sat_ref(lane_s(v, l));
        return r;
    endfunction

    function automatic logic [OW-1:0] splat(input longint x);
        logic [OW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*OUT_W +: OUT_W] = sat_ref(x);
        return r;
    endfunction

    function automatic logic [DW-1:0] beat_all(input int a, input int b, input int c, input int d);
        logic [DW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*64 +: 64] = {16'(d), 16'(c), 16'(b), 16'(a)};
        return v;
    endfunction

    function automatic logic [DW-1:0] beat_rand();
        logic [DW-1:0] v;
        for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic acc, input logic last);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_acc   = acc;
        in_last  = last;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            step();
            n++;
            if (!ok && n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_acc   = 1'b0;
        in_last  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_out_data: got %h, required 0", out_data);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        step();
    endtask

    task automatic test_plain();
        logic [DW-1:0] v;
        logic [OW-1:0] e;
        for (int l = 0; l < LANES; l++) begin
            v[l*64 +: 64] = {16'(5 + l), 16'(-2), 16'(4), 16'(3 + l)};
        end
        e = exp_plain(v);
        send(v, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL plain_lat_edge1: out_valid=%b, required 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL plain_lat_edge2: out_valid=%b, required 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL plain_lat_edge3: out_valid=%b, required 1", out_valid);
        end
        checks++;
        if (out_data[31:0] !== 32'd2) begin
            errors++;
            $display("FAIL plain_lane0: got %0d, required 2", $signed(out_data[31:0]));
        end
        checks++;
        if (out_data !== e) begin
            errors++;
            $display("FAIL plain_all_lanes: got %h, required %h", out_data, e);
        end
        repeat (2) step();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] exp_q[$];
        logic [DW-1:0] v;
        int start;
        obs_q.delete();
        start = cyc;
        for (int i = 0; i < 100; i++) begin
            v = beat_rand();
            exp_q.push_back(exp_plain(v));
            send(v, 1'b0, 1'b0);
        end
        checks++;
        if (cyc - start !== 100) begin
            errors++;
            $display("FAIL b2b_throughput: took %0d cycles, required 100", cyc - start);
        end
        repeat (PIPE_LAT + 2) step();
        checks++;
        if (obs_q.size() !== 100) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 100", obs_q.size());
        end
        for (int i = 0; i < 100 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_accumulate();
        obs_q.delete();
        for (int i = 0; i < 4; i++) send(beat_all(1000, 1000, 1000, 1000), 1'b1, i == 3);
        repeat (PIPE_LAT + 2) step();
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL acc_count: got %0d results, required 1", obs_q.size());
        end
        checks++;
        if (obs_q.size() > 0 && obs_q[0] !== splat(8000000)) begin
            errors++;
            $display("FAIL acc_sum: got %h, required %h", obs_q[0], splat(8000000));
        end
        send(beat_all(1, 1, 0, 0), 1'b1, 1'b1);
        repeat (PIPE_LAT + 2) step();
        checks++;
        if (obs_q.size() !== 2 || obs_q[obs_q.size()-1] !== splat(1)) begin
            errors++;
            $display("FAIL acc_cleared: got %0d results, last %h, required 2 results, last %h",
                     obs_q.size(), obs_q[obs_q.size()-1], splat(1));
        end
        obs_q.delete();
    endtask

    task automatic test_saturation();
        logic [DW-1:0] v;
        logic [OW-1:0] e;
        obs_q.delete();
        for (int i = 0; i < 3; i++) send(beat_all(-32768, -32768, -32768, -32768), 1'b1, i == 2);
        for (int i = 0; i < 2; i++) send(beat_all(-32768, 32767, -32768, 32767), 1'b1, i == 1);
        v = '0;
        v[63:0]   = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
        v[127:64] = {16'(5), 16'(-2), 16'(4), 16'(3)};
        e = exp_plain(v);
        send(v, 1'b0, 1'b0);
        repeat (PIPE_LAT + 2) step();
        checks++;
        if (obs_q.size() !== 3) begin
            errors++;
            $display("FAIL sat_count: got %0d results, required 3", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== splat(64'sd6442450944)) begin
                errors++;
                $display("FAIL sat_pos_group: got %h, required all 7fffffff", obs_q[0]);
            end
            checks++;
            if (obs_q[1] !== splat(-64'sd4294836224)) begin
                errors++;
                $display("FAIL sat_neg_group: got %h, required all 80000000", obs_q[1]);
            end
            checks++;
            if (obs_q[2][31:0] !== 32'h7FFF_FFFF) begin
                errors++;
                $display("FAIL sat_plain_lane0: got %h, required 7fffffff", obs_q[2][31:0]);
            end
            checks++;
            if (obs_q[2] !== e) begin
                errors++;
                $display("FAIL sat_plain_lanes: got %h, required %h", obs_q[2], e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] beats[10];
        logic [OW-1:0] exp_q[$];
        logic [OW-1:0] held;
        obs_q.delete();
        for (int i = 0; i < 10; i++) begin
            beats[i] = beat_rand();
            exp_q.push_back(exp_plain(beats[i]));
        end
        fork
            begin
                for (int i = 0; i < 10; i++) send(beats[i], 1'b0, 1'b0);
            end
            begin
                repeat (4) step();
                out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    if (j == 0) held = out_data;
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b, required 0 and 1",
                                 j, in_ready, out_valid);
                    end
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL bp_stable[%0d]: got %h, required %h", j, out_data, held);
                    end
                    step();
                end
                out_ready = 1'b1;
            end
        join
        repeat (PIPE_LAT + 2) step();
        checks++;
        if (obs_q.size() !== 10) begin
            errors++;
            $display("FAIL bp_count: got %0d results, required 10", obs_q.size());
        end
        for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_interleave();
        obs_q.delete();
        send(beat_all(2, 2, 2, 2), 1'b1, 1'b0);
        send(beat_all(1, 1, 1, 1), 1'b0, 1'b1);
        send(beat_all(2, 2, 2, 2), 1'b1, 1'b1);
        repeat (PIPE_LAT + 2) step();
        checks++;
        if (obs_q.size() !== 2) begin
            errors++;
            $display("FAIL il_count: got %0d results, required 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== splat(2)) begin
                errors++;
                $display("FAIL il_plain: got %h, required %h", obs_q[0], splat(2));
            end
            checks++;
            if (obs_q[1] !== splat(16)) begin
                errors++;
                $display("FAIL il_group: got %h, required %h", obs_q[1], splat(16));
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_group();
        send(beat_all(10, 10, 0, 0), 1'b1, 1'b0);
        send(beat_all(10, 10, 0, 0), 1'b1, 1'b0);
        repeat (PIPE_LAT) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: out_valid=%b out_data=%h, required 0 and 0",
                     out_valid, out_data);
        end
        step();
        reset = 1'b0;
        obs_q.delete();
        send(beat_all(7, 1, 0, 0), 1'b1, 1'b1);
        repeat (PIPE_LAT + 2) step();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== splat(7)) begin
            errors++;
            $display("FAIL rst_mid_group: got %0d results, first %h, required 1 result %h",
                     obs_q.size(), obs_q[0], splat(7));
        end
        obs_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_plain();
        test_back_to_back();
        test_accumulate();
        test_saturation();
        test_back_pressure();
        test_interleave();
        test_reset_mid_group();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
